// File: rtl/midi_osc.sv
// Wavetable oscillator voice: phase accumulator -> waveform ROM address -> gain-scaled sample out.
// Latency: 2 cycles from accepted smpl_tick to out_valid (ROM address stage, then scaling stage).
// Backpressure: out_valid held until out_ready; a tick arriving while busy/blocked is dropped and flagged on overrun.
module midi_osc #(
    parameter int PHASE_W = 24,
    parameter int IDX_W   = 6,
    parameter int SMPL_W  = 16,
    parameter int VEL_W   = 7
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               smpl_tick,
    input  logic               note_on,
    input  logic               note_off,
    input  logic [PHASE_W-1:0] note_inc,
    input  logic [VEL_W-1:0]   note_vel,
    output logic [IDX_W-1:0]   fnt_idx,
    input  logic [SMPL_W-1:0]  fnt_smpl,
    output logic [SMPL_W-1:0]  out_smpl,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               active,
    output logic               overrun
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_PLAY = 2'd1;
    localparam logic [1:0] ST_REL  = 2'd2;

    // Product of a signed sample and a zero-extended 7-bit gain fits in SMPL_W+VEL_W signed bits.
    localparam int PROD_W = SMPL_W + VEL_W;

    logic [1:0]                state;
    logic [PHASE_W-1:0]        phase;
    logic [PHASE_W-1:0]        inc;
    logic [VEL_W-1:0]          gain;
    logic [VEL_W-1:0]          s1_gain;
    logic                      s1_vld;
    logic                      tick_acc;
    logic                      note_start;
    logic                      note_rel;
    logic signed [PROD_W-1:0]  smpl_ext;
    logic signed [PROD_W-1:0]  gain_ext;
    logic signed [PROD_W-1:0]  prod;

    // A tick is taken only when the scaling stage is empty and the output slot is free or draining now.
    assign tick_acc   = smpl_tick & ~s1_vld & ~(out_valid & ~out_ready);
    // Velocity zero on note_on is a release request; a real note_on always beats note_off.
    assign note_start = note_on & (note_vel != '0);
    assign note_rel   = note_off | (note_on & (note_vel == '0));
    assign active     = (state != ST_IDLE);

    assign smpl_ext = PROD_W'($signed(fnt_smpl));
    assign gain_ext = PROD_W'({1'b0, s1_gain});
    assign prod     = smpl_ext * gain_ext;

    // Voice control: phase advance and release decay on accepted ticks, note events applied last.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            phase <= '0;
            inc   <= '0;
            gain  <= '0;
        end else begin
            if (tick_acc) begin
                if (state != ST_IDLE) begin
                    phase <= phase + inc;
                end
                if (state == ST_REL) begin
                    gain <= gain - VEL_W'(1);
                    if (gain == VEL_W'(1)) begin
                        state <= ST_IDLE;
                    end
                end
            end
            if (note_start) begin
                phase <= '0;
                inc   <= note_inc;
                gain  <= note_vel;
                state <= ST_PLAY;
            end else if (note_rel && (state == ST_PLAY)) begin
                state <= ST_REL;
            end
        end
    end

    // Address stage: present the pre-increment phase to the ROM and capture the gain that goes with it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fnt_idx <= '0;
            s1_gain <= '0;
            s1_vld  <= 1'b0;
            overrun <= 1'b0;
        end else begin
            overrun <= smpl_tick & ~tick_acc;
            s1_vld  <= tick_acc;
            if (tick_acc) begin
                fnt_idx <= phase[PHASE_W-1 -: IDX_W];
                s1_gain <= (state == ST_IDLE) ? '0 : gain;
            end
        end
    end

    // Scaling stage and output holding register; a new sample may replace one being accepted this edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_smpl  <= '0;
            out_valid <= 1'b0;
        end else if (s1_vld) begin
            out_smpl  <= SMPL_W'(prod >>> VEL_W);
            out_valid <= 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_midi_osc.sv
// Randomised and directed stimulus for midi_osc with a queue-based scoreboard.
// Expected samples are pushed when a tick is issued; a negedge monitor pops them on each handshake.
// The reference voice model works on whole notes, integer gains and floor-division scaling.
`timescale 1ns/1ps
module tb_midi_osc;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        smpl_tick;
    logic        note_on;
    logic        note_off;
    logic [23:0] note_inc;
    logic [6:0]  note_vel;
    logic [5:0]  fnt_idx;
    logic [15:0] fnt_smpl;
    logic [15:0] out_smpl;
    logic        out_valid;
    logic        out_ready;
    logic        active;
    logic        overrun;

    logic signed [15:0] rom [64];
    assign fnt_smpl = rom[fnt_idx];

    midi_osc dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .smpl_tick(smpl_tick),
        .note_on  (note_on),
        .note_off (note_off),
        .note_inc (note_inc),
        .note_vel (note_vel),
        .fnt_idx  (fnt_idx),
        .fnt_smpl (fnt_smpl),
        .out_smpl (out_smpl),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .active   (active),
        .overrun  (overrun)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [15:0] smpl;
        int          cyc;
    } exp_t;
    exp_t q[$];
    bit   fresh = 1'b1;

    typedef enum int {V_IDLE, V_PLAY, V_REL} vstate_t;
    vstate_t     m_st = V_IDLE;
    logic [23:0] m_phase = '0;
    logic [23:0] m_inc = '0;
    int          m_gain = 0;
    logic [5:0]  m_idx = '0;
    bit          m_inflight = 1'b0;
    bit          m_held = 1'b0;
    bit          e_ovr = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s at cycle %0d: actual=%0h required=%0h", name, cyc, act, req);
        end
    endtask

    // Floor of sample*gain/128, i.e. the gain applied as a fraction of full velocity.
    function automatic logic [15:0] scale(input logic signed [15:0] s, input int g);
        int p;
        p = int'(s) * g;
        return 16'(p >>> 7);
    endfunction

    // One clock: apply inputs, advance the reference model, then check registered outputs after the edge.
    task automatic step(input bit rst, input bit tick, input bit on, input bit off,
                        input logic [23:0] inc, input logic [6:0] vel, input bit rdy);
        bit acc;
        int g;
        rst_n     = !rst;
        smpl_tick = tick;
        note_on   = on;
        note_off  = off;
        note_inc  = inc;
        note_vel  = vel;
        out_ready = rdy;
        if (rst) begin
            m_st = V_IDLE; m_phase = '0; m_inc = '0; m_gain = 0; m_idx = '0;
            m_inflight = 1'b0; m_held = 1'b0; e_ovr = 1'b0;
            q.delete();
            fresh = 1'b1;
        end else begin
            // The voice can take a new tick only when no sample is still being scaled
            // and the downstream slot is empty or being emptied this cycle.
            acc   = tick && !m_inflight && !(m_held && !rdy);
            e_ovr = tick && !acc;
            if (m_inflight)          m_held = 1'b1;
            else if (m_held && rdy)  m_held = 1'b0;
            m_inflight = acc;
            if (acc) begin
                m_idx = m_phase[23:18];
                g = (m_st == V_IDLE) ? 0 : m_gain;
                q.push_back('{smpl: scale(rom[m_idx], g), cyc: cyc + 2});
                if (m_st != V_IDLE) m_phase = m_phase + m_inc;
                if (m_st == V_REL) begin
                    m_gain--;
                    if (m_gain == 0) m_st = V_IDLE;
                end
            end
            if (on && vel != 7'd0) begin
                m_phase = '0; m_inc = inc; m_gain = int'(vel); m_st = V_PLAY;
            end else if ((off || on) && m_st == V_PLAY) begin
                m_st = V_REL;
            end
        end
        @(posedge clk);
        #1;
        chk("active", 32'(active), 32'(m_st != V_IDLE));
        chk("overrun", 32'(overrun), 32'(e_ovr));
        chk("fnt_idx", 32'(fnt_idx), 32'(m_idx));
        if (rst) begin
            chk("rst_out_valid", 32'(out_valid), 32'd0);
            chk("rst_out_smpl", 32'(out_smpl), 32'd0);
        end
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 24'd0, 7'd0, rdy);
    endtask

    task automatic ticks(input int n, input int gap, input bit rdy);
        for (int i = 0; i < n; i++) begin
            step(1'b0, 1'b1, 1'b0, 1'b0, 24'd0, 7'd0, rdy);
            idle(gap - 1, rdy);
        end
    endtask

    // Monitor: latency on first appearance of each sample, value on its handshake.
    initial begin : monitor
        forever begin
            @(negedge clk);
            if (rst_n && out_valid) begin
                if (q.size() == 0) begin
                    chk("unexpected_sample", 32'(out_smpl), 32'hFFFF_FFFF);
                end else begin
                    if (fresh) begin
                        chk("latency", 32'(cyc), 32'(q[0].cyc));
                        fresh = 1'b0;
                    end
                    if (out_ready) begin
                        chk("sample", 32'(out_smpl), 32'(q[0].smpl));
                        void'(q.pop_front());
                        fresh = 1'b1;
                    end
                end
            end
        end
    end

    initial begin : driver
        for (int i = 0; i < 64; i++) rom[i] = 16'($urandom);
        rom[0]  = 16'sh8000;
        rom[1]  = 16'sh7FFF;
        rom[19] = 16'sh38FD;
        rom[46] = 16'shE2BC;
        rst_n = 1'b0; smpl_tick = 1'b0; note_on = 1'b0; note_off = 1'b0;
        note_inc = '0; note_vel = '0; out_ready = 1'b0;

        // Reset for two cycles, then silent ticks while idle.
        step(1'b1, 1'b0, 1'b0, 1'b0, 24'd0, 7'd0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 24'd0, 7'd0, 1'b0);
        ticks(4, 8, 1'b1);

        // Full-velocity note stepping one ROM entry per tick, past the phase wrap.
        step(1'b0, 1'b0, 1'b1, 1'b0, 24'h040000, 7'd127, 1'b1);
        ticks(70, 8, 1'b1);

        // Half velocity, wrap again.
        step(1'b0, 1'b0, 1'b1, 1'b0, 24'h040000, 7'd64, 1'b1);
        ticks(68, 8, 1'b1);

        // Low velocity then release: gains 3,2,1 then silence.
        step(1'b0, 1'b0, 1'b1, 1'b0, 24'h040000, 7'd3, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b1, 24'd0, 7'd0, 1'b1);
        ticks(6, 8, 1'b1);

        // Backpressure: a held sample blocks the next tick, which is dropped.
        step(1'b0, 1'b0, 1'b1, 1'b0, 24'h123456, 7'd100, 1'b1);
        idle(2, 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b0, 24'd0, 7'd0, 1'b0);
        idle(3, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 24'd0, 7'd0, 1'b0);
        idle(2, 1'b0);
        idle(1, 1'b1);
        ticks(3, 4, 1'b1);

        // Note-event priority, velocity-zero release, reset with a sample in flight.
        step(1'b0, 1'b0, 1'b1, 1'b1, 24'h0A0000, 7'd90, 1'b1);
        ticks(2, 5, 1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b0, 24'h0A0000, 7'd0, 1'b1);
        ticks(3, 5, 1'b1);
        step(1'b0, 1'b1, 1'b1, 1'b0, 24'h0B0000, 7'd50, 1'b1);
        ticks(2, 4, 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b0, 24'd0, 7'd0, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b0, 24'd0, 7'd0, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b0, 24'd0, 7'd0, 1'b1);
        ticks(2, 4, 1'b1);

        // Random traffic.
        for (int i = 0; i < 4000; i++) begin
            bit          r_rst, r_tick, r_on, r_off, r_rdy;
            logic [23:0] r_inc;
            logic [6:0]  r_vel;
            r_rst  = ($urandom_range(0, 499) == 0);
            r_tick = ($urandom_range(0, 2) == 0);
            r_on   = ($urandom_range(0, 39) == 0);
            r_off  = ($urandom_range(0, 29) == 0);
            r_rdy  = ($urandom_range(0, 3) != 0);
            r_inc  = 24'($urandom);
            r_vel  = ($urandom_range(0, 7) == 0) ? 7'd0 : 7'($urandom_range(1, 127));
            step(r_rst, r_tick, r_on, r_off, r_inc, r_vel, r_rdy);
        end

        // Drain and confirm every expected sample was delivered.
        idle(10, 1'b1);
        chk("queue_drained", 32'(q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
